// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS core: sequences fetch/decode/execute/writeback,
// selects the immediate extension mode and stalls on the memory-ready handshake.
module multicycle_controller #(
    parameter int OP_W     = 6,
    parameter int STATE_W  = 4,
    parameter int MEM_WAIT = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [OP_W-1:0]    op,
    input  logic [OP_W-1:0]    funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               iord,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_control,
    output logic [1:0]         pc_src,
    output logic               pc_en,
    output logic               ext_zero,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [STATE_W-1:0] S_FETCH   = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE  = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR  = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMRD   = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB   = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWR   = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXECUTE = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_ALUWB   = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_BRANCH  = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_IEXEC   = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_IWB     = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_JUMP    = STATE_W'(11);

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

    localparam logic [OP_W-1:0] FN_ADD = OP_W'(6'b100000);
    localparam logic [OP_W-1:0] FN_SUB = OP_W'(6'b100010);
    localparam logic [OP_W-1:0] FN_AND = OP_W'(6'b100100);
    localparam logic [OP_W-1:0] FN_OR  = OP_W'(6'b100101);
    localparam logic [OP_W-1:0] FN_SLT = OP_W'(6'b101010);

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [STATE_W-1:0] state_reg;
    logic [STATE_W-1:0] state_next;
    logic               rdy;
    logic               funct_ok;
    logic [2:0]         funct_alu;
    logic               op_ok;
    logic               imm_zext;
    logic [2:0]         imm_alu;

    assign rdy     = (MEM_WAIT != 0) ? mem_ready : 1'b1;
    assign state_o = state_reg;

    // Instruction-field decode shared by next-state and output logic.
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        imm_zext = 1'b0;
        imm_alu  = ALU_ADD;
        case (op)
            OP_ANDI: begin
                imm_zext = 1'b1;
                imm_alu  = ALU_AND;
            end
            OP_ORI: begin
                imm_zext = 1'b1;
                imm_alu  = ALU_OR;
            end
            default: ;
        endcase
    end

    always_comb begin
        op_ok = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_J: op_ok = 1'b1;
            default: op_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:   state_next = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:               state_next = S_MEMADR;
                    OP_RTYPE:                   state_next = S_EXECUTE;
                    OP_BEQ:                     state_next = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI:   state_next = S_IEXEC;
                    OP_J:                       state_next = S_JUMP;
                    default:                    state_next = S_FETCH;
                endcase
            end
            S_MEMADR:  state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_next = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_next = S_FETCH;
            S_MEMWR:   state_next = rdy ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_next = funct_ok ? S_ALUWB : S_FETCH;
            S_ALUWB:   state_next = S_FETCH;
            S_BRANCH:  state_next = S_FETCH;
            S_IEXEC:   state_next = S_IWB;
            S_IWB:     state_next = S_FETCH;
            S_JUMP:    state_next = S_FETCH;
            default:   state_next = S_FETCH;
        endcase
    end

    // Outputs follow the state register; only the documented fields look at inputs.
    always_comb begin
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        pc_src      = 2'b00;
        pc_en       = 1'b0;
        ext_zero    = 1'b0;
        illegal_op  = 1'b0;
        case (state_reg)
            S_FETCH: begin
                alu_src_b   = 2'b01;
                alu_control = ALU_ADD;
                ir_write    = rdy;
                pc_en       = rdy;
            end
            S_DECODE: begin
                alu_src_b   = 2'b11;
                alu_control = ALU_ADD;
                illegal_op  = !op_ok;
            end
            S_MEMADR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = ALU_ADD;
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a   = 1'b1;
                alu_control = funct_alu;
                illegal_op  = !funct_ok;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = 2'b01;
                pc_en       = zero;
            end
            S_IEXEC: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = imm_alu;
                ext_zero    = imm_zext;
            end
            S_IWB: begin
                reg_write = 1'b1;
                ext_zero  = imm_zext;
            end
            S_JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: each cycle's expected state and control word is
// queued as the stimulus is applied, then popped and compared on the falling edge.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_src;
    logic       pc_en, ext_zero, illegal_op;
    logic [3:0] state_o;
    logic [16:0] ctl_obs;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [16:0] ctl;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    multicycle_controller dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .pc_src(pc_src), .pc_en(pc_en), .ext_zero(ext_zero), .illegal_op(illegal_op),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign ctl_obs = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                      alu_src_b, alu_control, pc_src, pc_en, ext_zero, illegal_op};

    function automatic logic [16:0] cw(input logic io, mw, irw, rd, m2r, rw, sa,
                                       input logic [1:0] sbv, input logic [2:0] alu,
                                       input logic [1:0] pcs, input logic pce, ez, ill);
        return {io, mw, irw, rd, m2r, rw, sa, sbv, alu, pcs, pce, ez, ill};
    endfunction

    task automatic step(input string tag, input logic [5:0] o, input logic [5:0] f,
                        input logic z, input logic r, input logic [3:0] es,
                        input logic [16:0] ec);
        exp_t e;
        op = o; funct = f; zero = z; mem_ready = r;
        sb.push_back('{tag, es, ec});
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        assert (state_o === e.st) else begin
            failures++;
            $error("FAIL %s state observed=%0d expected=%0d", e.tag, state_o, e.st);
        end
        checks++;
        assert (ctl_obs === e.ctl) else begin
            failures++;
            $error("FAIL %s ctl observed=%b expected=%b", e.tag, ctl_obs, e.ctl);
        end
        $display("step %s state=%0d ctl=%b", e.tag, state_o, ctl_obs);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] f0, f1, dec, dec_ill, madr, mrd, mwb, mwr, awb, jmp;
        f1      = cw(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0,0);
        f0      = cw(0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0,0);
        dec     = cw(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0,0);
        dec_ill = cw(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0,1);
        madr    = cw(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0,0);
        mrd     = cw(1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,0);
        mwb     = cw(0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0,0,0);
        mwr     = cw(1,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,0);
        awb     = cw(0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0,0,0);
        jmp     = cw(0,0,0,0,0,0,0,2'b00,3'b000,2'b10,1,0,0);

        reset_n = 1'b0; op = 6'b0; funct = 6'b0; zero = 1'b0; mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        assert (state_o === 4'd0 && ctl_obs === f0) else begin
            failures++;
            $error("FAIL reset state=%0d ctl=%b expected state=0 ctl=%b", state_o, ctl_obs, f0);
        end
        reset_n = 1'b1;

        // Fetch stall then lw with no memory wait
        step("fetch_wait", 6'b100011, 6'b0, 0, 0, 4'd0, f0);
        step("lw_fetch",   6'b100011, 6'b0, 0, 1, 4'd0, f1);
        step("lw_decode",  6'b100011, 6'b0, 0, 1, 4'd1, dec);
        step("lw_memadr",  6'b100011, 6'b0, 0, 1, 4'd2, madr);
        step("lw_memrd",   6'b100011, 6'b0, 0, 1, 4'd3, mrd);
        step("lw_memwb",   6'b100011, 6'b0, 0, 1, 4'd4, mwb);

        // lw with one wait cycle in MEMRD
        step("lw2_fetch",  6'b100011, 6'b0, 0, 1, 4'd0, f1);
        step("lw2_decode", 6'b100011, 6'b0, 0, 1, 4'd1, dec);
        step("lw2_memadr", 6'b100011, 6'b0, 0, 1, 4'd2, madr);
        step("lw2_rdwait", 6'b100011, 6'b0, 0, 0, 4'd3, mrd);
        step("lw2_memrd",  6'b100011, 6'b0, 0, 1, 4'd3, mrd);
        step("lw2_memwb",  6'b100011, 6'b0, 0, 1, 4'd4, mwb);

        // sw with two wait cycles in MEMWR
        step("sw_fetch",   6'b101011, 6'b0, 0, 1, 4'd0, f1);
        step("sw_decode",  6'b101011, 6'b0, 0, 1, 4'd1, dec);
        step("sw_memadr",  6'b101011, 6'b0, 0, 1, 4'd2, madr);
        step("sw_wr0",     6'b101011, 6'b0, 0, 0, 4'd5, mwr);
        step("sw_wr1",     6'b101011, 6'b0, 0, 0, 4'd5, mwr);
        step("sw_wr2",     6'b101011, 6'b0, 0, 1, 4'd5, mwr);
        step("sw_back",    6'b001100, 6'b0, 0, 1, 4'd0, f1);

        // andi, addi, ori
        step("andi_decode", 6'b001100, 6'b0, 0, 1, 4'd1, dec);
        step("andi_iexec",  6'b001100, 6'b0, 0, 1, 4'd9, cw(0,0,0,0,0,0,1,2'b10,3'b000,2'b00,0,1,0));
        step("andi_iwb",    6'b001100, 6'b0, 0, 1, 4'd10, cw(0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0,1,0));
        step("addi_fetch",  6'b001000, 6'b0, 0, 1, 4'd0, f1);
        step("addi_decode", 6'b001000, 6'b0, 0, 1, 4'd1, dec);
        step("addi_iexec",  6'b001000, 6'b0, 0, 1, 4'd9, cw(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0,0));
        step("addi_iwb",    6'b001000, 6'b0, 0, 1, 4'd10, cw(0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0,0,0));
        step("ori_fetch",   6'b001101, 6'b0, 0, 1, 4'd0, f1);
        step("ori_decode",  6'b001101, 6'b0, 0, 1, 4'd1, dec);
        step("ori_iexec",   6'b001101, 6'b0, 0, 1, 4'd9, cw(0,0,0,0,0,0,1,2'b10,3'b001,2'b00,0,1,0));
        step("ori_iwb",     6'b001101, 6'b0, 0, 1, 4'd10, cw(0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0,1,0));

        // beq taken and not taken
        step("beq1_fetch",  6'b000100, 6'b0, 0, 1, 4'd0, f1);
        step("beq1_decode", 6'b000100, 6'b0, 0, 1, 4'd1, dec);
        step("beq1_branch", 6'b000100, 6'b0, 1, 1, 4'd8, cw(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,1,0,0));
        step("beq0_fetch",  6'b000100, 6'b0, 0, 1, 4'd0, f1);
        step("beq0_decode", 6'b000100, 6'b0, 1, 1, 4'd1, dec);
        step("beq0_branch", 6'b000100, 6'b0, 0, 1, 4'd8, cw(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,0,0,0));

        // jump
        step("j_fetch",     6'b000010, 6'b0, 0, 1, 4'd0, f1);
        step("j_decode",    6'b000010, 6'b0, 0, 1, 4'd1, dec);
        step("j_jump",      6'b000010, 6'b0, 0, 1, 4'd11, jmp);

        // illegal opcode, then illegal funct
        step("ill_fetch",   6'b111111, 6'b0, 0, 1, 4'd0, f1);
        step("ill_decode",  6'b111111, 6'b0, 0, 1, 4'd1, dec_ill);
        step("illf_fetch",  6'b000000, 6'b000000, 0, 1, 4'd0, f1);
        step("illf_decode", 6'b000000, 6'b000000, 0, 1, 4'd1, dec);
        step("illf_exec",   6'b000000, 6'b000000, 0, 1, 4'd6, cw(0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0,0,1));

        // R-type sub and slt
        step("sub_fetch",   6'b000000, 6'b100010, 0, 1, 4'd0, f1);
        step("sub_decode",  6'b000000, 6'b100010, 0, 1, 4'd1, dec);
        step("sub_exec",    6'b000000, 6'b100010, 0, 1, 4'd6, cw(0,0,0,0,0,0,1,2'b00,3'b110,2'b00,0,0,0));
        step("sub_aluwb",   6'b000000, 6'b100010, 0, 1, 4'd7, awb);
        step("slt_fetch",   6'b000000, 6'b101010, 0, 1, 4'd0, f1);
        step("slt_decode",  6'b000000, 6'b101010, 0, 1, 4'd1, dec);
        step("slt_exec",    6'b000000, 6'b101010, 0, 1, 4'd6, cw(0,0,0,0,0,0,1,2'b00,3'b111,2'b00,0,0,0));
        step("slt_aluwb",   6'b000000, 6'b101010, 0, 1, 4'd7, awb);

        // Reset while a store is stalled: mem_write must drop without a clock edge
        step("rst_fetch",   6'b101011, 6'b0, 0, 1, 4'd0, f1);
        step("rst_decode",  6'b101011, 6'b0, 0, 1, 4'd1, dec);
        step("rst_memadr",  6'b101011, 6'b0, 0, 1, 4'd2, madr);
        op = 6'b101011; mem_ready = 1'b0;
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        assert (state_o === 4'd0 && mem_write === 1'b0) else begin
            failures++;
            $error("FAIL async_reset state=%0d mem_write=%b expected state=0 mem_write=0",
                   state_o, mem_write);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step("post_reset",  6'b101011, 6'b0, 0, 1, 4'd0, f1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
